// File: rtl/lsu_dtcm_agent.sv
// Single-outstanding load/store agent in front of the DTCM: checks alignment/range, issues one command,
// captures the one-cycle response and hands an extended result to writeback. All outputs registered or state-decoded.
module lsu_dtcm_agent #(
  parameter int          DTCM_AW   = 16,
  parameter logic [31:0] DTCM_BASE = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               exu2lsu_valid,
  output logic               exu2lsu_ready,
  input  logic               exu2lsu_load,
  input  logic [1:0]         exu2lsu_size,
  input  logic               exu2lsu_unsigned,
  input  logic [31:0]        exu2lsu_addr,
  input  logic [31:0]        exu2lsu_wdata,
  input  logic [4:0]         exu2lsu_rd_idx,
  output logic               lsu2dtcm_cmd_valid,
  input  logic               lsu2dtcm_cmd_ready,
  output logic               lsu2dtcm_cmd_read,
  output logic [DTCM_AW-1:0] lsu2dtcm_cmd_addr,
  output logic [3:0]         lsu2dtcm_cmd_wmask,
  output logic [31:0]        lsu2dtcm_cmd_wdata,
  input  logic               lsu2dtcm_rsp_valid,
  output logic               lsu2dtcm_rsp_ready,
  input  logic [31:0]        lsu2dtcm_rsp_rdata,
  output logic               lsu2wb_valid,
  input  logic               lsu2wb_ready,
  output logic               lsu2wb_wen,
  output logic [4:0]         lsu2wb_rd_idx,
  output logic [31:0]        lsu2wb_rdata,
  output logic               lsu2wb_err
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic               load_q, uns_q, err_q;
  logic [1:0]         size_q;
  logic [DTCM_AW-1:0] addr_q;
  logic [3:0]         wmask_q;
  logic [31:0]        wdata_q, result_q;
  logic [4:0]         rd_q;

  logic               in_err;
  logic [3:0]         in_wmask;
  logic [31:0]        in_wdata;
  logic [31:0]        rsp_shift;
  logic [31:0]        ld_ext;

  wire accept = (state_q == IDLE) && exu2lsu_valid;
  wire rsp_hit = (state_q == WAIT) && lsu2dtcm_rsp_valid;

  always_comb begin
    in_err   = 1'b0;
    in_wmask = 4'b0000;
    in_wdata = exu2lsu_wdata;
    case (exu2lsu_size)
      2'd0: begin
        in_wmask = 4'b0001 << exu2lsu_addr[1:0];
        in_wdata = {4{exu2lsu_wdata[7:0]}};
      end
      2'd1: begin
        in_err   = exu2lsu_addr[0];
        in_wmask = 4'b0011 << {exu2lsu_addr[1], 1'b0};
        in_wdata = {2{exu2lsu_wdata[15:0]}};
      end
      2'd2: begin
        in_err   = (exu2lsu_addr[1:0] != 2'b00);
        in_wmask = 4'b1111;
      end
      default: in_err = 1'b1;
    endcase
    if (exu2lsu_addr[31:DTCM_AW] != DTCM_BASE[31:DTCM_AW])
      in_err = 1'b1;
    if (exu2lsu_load)
      in_wmask = 4'b0000;
  end

  // Lane select uses the registered address, so extraction happens on the response path only.
  always_comb begin
    rsp_shift = lsu2dtcm_rsp_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    ld_ext = {{24{~uns_q & rsp_shift[7]}}, rsp_shift[7:0]};
      2'd1:    ld_ext = {{16{~uns_q & rsp_shift[15]}}, rsp_shift[15:0]};
      default: ld_ext = lsu2dtcm_rsp_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (exu2lsu_valid) state_d = in_err ? DONE : CMD;
      CMD:  if (lsu2dtcm_cmd_ready) state_d = WAIT;
      WAIT: if (lsu2dtcm_rsp_valid) state_d = DONE;
      DONE: if (lsu2wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q   <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wmask_q  <= 4'b0000;
      wdata_q  <= 32'd0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
    end else if (accept) begin
      load_q   <= exu2lsu_load;
      uns_q    <= exu2lsu_unsigned;
      err_q    <= in_err;
      size_q   <= exu2lsu_size;
      addr_q   <= exu2lsu_addr[DTCM_AW-1:0];
      wmask_q  <= in_wmask;
      wdata_q  <= in_wdata;
      rd_q     <= exu2lsu_rd_idx;
      result_q <= 32'd0;
    end else if (rsp_hit && load_q) begin
      result_q <= ld_ext;
    end
  end

  assign exu2lsu_ready      = (state_q == IDLE);
  assign lsu2dtcm_cmd_valid = (state_q == CMD);
  assign lsu2dtcm_rsp_ready = (state_q == WAIT);
  assign lsu2dtcm_cmd_read  = load_q;
  assign lsu2dtcm_cmd_addr  = addr_q;
  assign lsu2dtcm_cmd_wmask = wmask_q;
  assign lsu2dtcm_cmd_wdata = wdata_q;
  assign lsu2wb_valid       = (state_q == DONE);
  assign lsu2wb_wen         = (state_q == DONE) && load_q && !err_q;
  assign lsu2wb_err         = (state_q == DONE) && err_q;
  assign lsu2wb_rd_idx      = rd_q;
  assign lsu2wb_rdata       = result_q;

endmodule

// File: tb/tb_lsu_dtcm_agent.sv
// Directed bench for lsu_dtcm_agent: loads/stores, error paths, backpressure and mid-transaction reset.
module tb_lsu_dtcm_agent;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu2lsu_valid, exu2lsu_ready, exu2lsu_load, exu2lsu_unsigned;
  logic [1:0]  exu2lsu_size;
  logic [31:0] exu2lsu_addr, exu2lsu_wdata;
  logic [4:0]  exu2lsu_rd_idx;
  logic        lsu2dtcm_cmd_valid, lsu2dtcm_cmd_ready, lsu2dtcm_cmd_read;
  logic [15:0] lsu2dtcm_cmd_addr;
  logic [3:0]  lsu2dtcm_cmd_wmask;
  logic [31:0] lsu2dtcm_cmd_wdata;
  logic        lsu2dtcm_rsp_valid, lsu2dtcm_rsp_ready;
  logic [31:0] lsu2dtcm_rsp_rdata;
  logic        lsu2wb_valid, lsu2wb_ready, lsu2wb_wen, lsu2wb_err;
  logic [4:0]  lsu2wb_rd_idx;
  logic [31:0] lsu2wb_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_dtcm_agent #(.DTCM_AW(16), .DTCM_BASE(32'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu2lsu_valid(exu2lsu_valid), .exu2lsu_ready(exu2lsu_ready),
    .exu2lsu_load(exu2lsu_load), .exu2lsu_size(exu2lsu_size),
    .exu2lsu_unsigned(exu2lsu_unsigned), .exu2lsu_addr(exu2lsu_addr),
    .exu2lsu_wdata(exu2lsu_wdata), .exu2lsu_rd_idx(exu2lsu_rd_idx),
    .lsu2dtcm_cmd_valid(lsu2dtcm_cmd_valid), .lsu2dtcm_cmd_ready(lsu2dtcm_cmd_ready),
    .lsu2dtcm_cmd_read(lsu2dtcm_cmd_read), .lsu2dtcm_cmd_addr(lsu2dtcm_cmd_addr),
    .lsu2dtcm_cmd_wmask(lsu2dtcm_cmd_wmask), .lsu2dtcm_cmd_wdata(lsu2dtcm_cmd_wdata),
    .lsu2dtcm_rsp_valid(lsu2dtcm_rsp_valid), .lsu2dtcm_rsp_ready(lsu2dtcm_rsp_ready),
    .lsu2dtcm_rsp_rdata(lsu2dtcm_rsp_rdata),
    .lsu2wb_valid(lsu2wb_valid), .lsu2wb_ready(lsu2wb_ready), .lsu2wb_wen(lsu2wb_wen),
    .lsu2wb_rd_idx(lsu2wb_rd_idx), .lsu2wb_rdata(lsu2wb_rdata), .lsu2wb_err(lsu2wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    exu2lsu_valid = 1'b1; exu2lsu_load = ld; exu2lsu_size = sz; exu2lsu_unsigned = uns;
    exu2lsu_addr = a; exu2lsu_wdata = wd; exu2lsu_rd_idx = rd;
    chk("exu_ready_idle", {31'd0, exu2lsu_ready}, 32'd1);
    step();
    exu2lsu_valid = 1'b0;
  endtask

  // Full good-path op with immediate cmd_ready, response in WAIT's first cycle, wb_ready=1.
  task automatic mem_op(input string nm, input logic ld, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rsp, input logic [3:0] exp_mask,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_res);
    issue(ld, sz, uns, a, wd, rd);
    chk({nm, "_cmd_valid"}, {31'd0, lsu2dtcm_cmd_valid}, 32'd1);
    chk({nm, "_cmd_read"}, {31'd0, lsu2dtcm_cmd_read}, {31'd0, ld});
    chk({nm, "_cmd_addr"}, {16'd0, lsu2dtcm_cmd_addr}, {16'd0, a[15:0]});
    chk({nm, "_cmd_wmask"}, {28'd0, lsu2dtcm_cmd_wmask}, {28'd0, exp_mask});
    if (!ld) chk({nm, "_cmd_wdata"}, lsu2dtcm_cmd_wdata, exp_wdata);
    step();
    chk({nm, "_rsp_ready"}, {31'd0, lsu2dtcm_rsp_ready}, 32'd1);
    chk({nm, "_wait_no_wb"}, {31'd0, lsu2wb_valid}, 32'd0);
    lsu2dtcm_rsp_valid = 1'b1; lsu2dtcm_rsp_rdata = rsp;
    step();
    lsu2dtcm_rsp_valid = 1'b0; lsu2dtcm_rsp_rdata = 32'h0;
    chk({nm, "_wb_valid"}, {31'd0, lsu2wb_valid}, 32'd1);
    chk({nm, "_wb_wen"}, {31'd0, lsu2wb_wen}, {31'd0, ld});
    chk({nm, "_wb_err"}, {31'd0, lsu2wb_err}, 32'd0);
    chk({nm, "_wb_rd"}, {27'd0, lsu2wb_rd_idx}, {27'd0, rd});
    chk({nm, "_wb_rdata"}, lsu2wb_rdata, exp_res);
    step();
    chk({nm, "_back_idle"}, {30'd0, lsu2wb_valid, exu2lsu_ready}, 32'd1);
  endtask

  task automatic err_op(input string nm, input logic ld, input logic [1:0] sz, input logic [31:0] a);
    issue(ld, sz, 1'b0, a, 32'h1234_5678, 5'd9);
    chk({nm, "_no_cmd"}, {31'd0, lsu2dtcm_cmd_valid}, 32'd0);
    chk({nm, "_wb_valid"}, {31'd0, lsu2wb_valid}, 32'd1);
    chk({nm, "_wb_err"}, {31'd0, lsu2wb_err}, 32'd1);
    chk({nm, "_wb_wen"}, {31'd0, lsu2wb_wen}, 32'd0);
    chk({nm, "_wb_rdata"}, lsu2wb_rdata, 32'd0);
    step();
    chk({nm, "_no_cmd_after"}, {30'd0, lsu2dtcm_cmd_valid, lsu2wb_valid}, 32'd0);
    chk({nm, "_back_idle"}, {31'd0, exu2lsu_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    exu2lsu_valid = 1'b0; exu2lsu_load = 1'b0; exu2lsu_size = 2'd0; exu2lsu_unsigned = 1'b0;
    exu2lsu_addr = 32'h0; exu2lsu_wdata = 32'h0; exu2lsu_rd_idx = 5'd0;
    lsu2dtcm_cmd_ready = 1'b1; lsu2dtcm_rsp_valid = 1'b0; lsu2dtcm_rsp_rdata = 32'h0;
    lsu2wb_ready = 1'b1;
    step(); step();
    chk("rst_exu_ready", {31'd0, exu2lsu_ready}, 32'd1);
    chk("rst_ctrl", {27'd0, lsu2dtcm_cmd_valid, lsu2dtcm_rsp_ready, lsu2wb_valid, lsu2wb_wen, lsu2wb_err}, 32'd0);
    chk("rst_cmd", {11'd0, lsu2dtcm_cmd_read, lsu2dtcm_cmd_addr, lsu2dtcm_cmd_wmask}, 32'd0);
    chk("rst_data", lsu2dtcm_cmd_wdata | lsu2wb_rdata | {27'd0, lsu2wb_rd_idx}, 32'd0);
    rst_n = 1'b1;
    step();

    mem_op("lb",  1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 5'd5, 32'h80FF_FF12, 4'b0000, 32'h0, 32'hFFFF_FF80);
    mem_op("lhu", 1'b1, 2'd1, 1'b1, 32'h8000_0002, 32'h0, 5'd6, 32'hBEEF_1234, 4'b0000, 32'h0, 32'h0000_BEEF);
    mem_op("lh",  1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 5'd7, 32'hBEEF_1234, 4'b0000, 32'h0, 32'hFFFF_BEEF);
    mem_op("lbu", 1'b1, 2'd0, 1'b1, 32'h8000_0100, 32'h0, 5'd8, 32'h0000_00F0, 4'b0000, 32'h0, 32'h0000_00F0);
    mem_op("lw",  1'b1, 2'd2, 1'b0, 32'h8000_FFFC, 32'h0, 5'd31, 32'h1357_9BDF, 4'b0000, 32'h0, 32'h1357_9BDF);
    mem_op("sb",  1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_00A5, 5'd3, 32'hFFFF_FFFF, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    mem_op("sh",  1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h7777_CAFE, 5'd4, 32'h1111_1111, 4'b1100, 32'hCAFE_CAFE, 32'h0);
    mem_op("sw",  1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h1234_5678, 5'd2, 32'h0, 4'b1111, 32'h1234_5678, 32'h0);

    err_op("lw_misalign", 1'b1, 2'd2, 32'h8000_0002);
    err_op("sh_range",    1'b0, 2'd1, 32'h9000_0000);
    err_op("lh_odd",      1'b1, 2'd1, 32'h8000_0001);
    err_op("size3",       1'b1, 2'd3, 32'h8000_0000);

    // Backpressure on both handshakes
    lsu2dtcm_cmd_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'hDEAD_BEEF, 5'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_cmd_valid", {30'd0, lsu2dtcm_cmd_valid, exu2lsu_ready}, 32'd2);
      chk("bp_cmd_addr", {16'd0, lsu2dtcm_cmd_addr}, 32'h0000_0008);
      chk("bp_cmd_wdata", lsu2dtcm_cmd_wdata, 32'hDEAD_BEEF);
      chk("bp_cmd_wmask", {28'd0, lsu2dtcm_cmd_wmask}, 32'hF);
      if (i == 2) lsu2dtcm_cmd_ready = 1'b1;
      step();
    end
    chk("bp_wait", {30'd0, lsu2dtcm_rsp_ready, lsu2dtcm_cmd_valid}, 32'd2);
    lsu2dtcm_rsp_valid = 1'b1; lsu2dtcm_rsp_rdata = 32'hCCCC_CCCC; lsu2wb_ready = 1'b0;
    step();
    lsu2dtcm_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_wb_valid", {30'd0, lsu2wb_valid, exu2lsu_ready}, 32'd2);
      chk("bp_wb_fields", {26'd0, lsu2wb_wen, lsu2wb_err, lsu2wb_rd_idx[3:0]}, 32'd1);
      chk("bp_wb_rdata", lsu2wb_rdata, 32'd0);
      if (i == 1) lsu2wb_ready = 1'b1;
      step();
    end
    chk("bp_release", {30'd0, lsu2wb_valid, exu2lsu_ready}, 32'd1);

    // Reset while waiting for the response
    issue(1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 5'd12);
    step();
    chk("rw_in_wait", {31'd0, lsu2dtcm_rsp_ready}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_ctrl", {26'd0, exu2lsu_ready, lsu2dtcm_cmd_valid, lsu2dtcm_rsp_ready, lsu2wb_valid, lsu2wb_wen, lsu2wb_err}, 32'h20);
    chk("rw_cmd", {11'd0, lsu2dtcm_cmd_read, lsu2dtcm_cmd_addr, lsu2dtcm_cmd_wmask}, 32'd0);
    chk("rw_rd", {27'd0, lsu2wb_rd_idx}, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    lsu2dtcm_rsp_valid = 1'b1; lsu2dtcm_rsp_rdata = 32'hFFFF_FFFF;
    step();
    lsu2dtcm_rsp_valid = 1'b0;
    chk("stray_rsp_no_wb", {30'd0, lsu2wb_valid, exu2lsu_ready}, 32'd1);
    chk("stray_rsp_rdata", lsu2wb_rdata, 32'd0);
    step();
    chk("stray_rsp_later", {31'd0, lsu2wb_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
